// File: rtl/mux_rr_sched.sv
// ============================================================================
// Module   : mux_rr_sched
// Brief    : Round-robin scheduler sharing one 4x1 bit mux among four
//            requesters, with a bounded burst length per grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in_data,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       out_data,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [3:0]          others;
  logic [2:0]          idle_pick;
  logic [2:0]          rr_pick;
  logic                release_g;
  logic                at_max;

  // Returns {found, index} of the first set bit searching start, start+1, ...
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Masking the holder keeps it out of its own re-arbitration.
  assign others    = req & ~gnt_q;
  assign idle_pick = pick(req, ptr_q);
  assign rr_pick   = pick(others, sel_q + 2'd1);
  assign release_g = ~req[sel_q];
  assign at_max    = (hold_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          gnt_d   = 4'b0001 << idle_pick[1:0];
          sel_d   = idle_pick[1:0];
          hold_d  = HOLD_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_g || (at_max && rr_pick[2])) begin
          ptr_d = sel_q + 2'd1;
          if (rr_pick[2]) begin
            gnt_d  = 4'b0001 << rr_pick[1:0];
            sel_d  = rr_pick[1:0];
            hold_d = HOLD_W'(1);
          end else begin
            gnt_d   = 4'b0000;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (!at_max) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        // at_max with no competitor: saturate, keep grant and count.
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[sel_q];
  assign out_data  = out_valid & in_data[sel_q];

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
// ============================================================================
// Module   : tb_mux_rr_sched
// Brief    : Table-driven scoreboard bench for mux_rr_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] in_data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux_rr_sched #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       valid;
    logic       data;
  } vec_t;

  vec_t tbl[$];
  logic [8:0] sb[$];

  function automatic void add(input logic rstn_i, input logic [3:0] r, input logic [3:0] d,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic v, input logic o);
    vec_t t;
    t.rstn = rstn_i; t.req = r; t.din = d; t.gnt = g; t.sel = s;
    t.busy = b; t.valid = v; t.data = o;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant must always be one-hot or zero and agree with sel.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (gnt != 4'b0000) chk("sel_matches_gnt", {28'd0, gnt}, {28'd0, 4'b0001 << sel});
    end
  end

  initial begin
    logic [3:0] din_pat;
    logic [8:0] e;
    int         idx;

    rst_n   = 1'b0;
    req     = 4'b0000;
    in_data = 4'b0000;

    // Single requester
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0010, 4'b0010, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1, 1);

    // Full load, MAX_HOLD=4: four cycles per requester, no gaps
    din_pat = 4'b1010;
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b1111, din_pat, 4'b0000, 2'd0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      idx = (k / 4) % 4;
      add(1, 4'b1111, din_pat, 4'b0001 << idx, 2'(idx), 1, 1, din_pat[idx]);
    end

    // Release hands over without a bubble, hold restarts
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0101, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 1, 0);
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 1, 0);
    add(1, 4'b0100, 4'b0000, 4'b0001, 2'd0, 1, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 1, 0);
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);

    // Data path through sel=2
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0100, 4'b1001, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b0100, 4'b1001, 4'b0100, 2'd2, 1, 1, 0);
    add(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1);

    // Saturation then preemption by a late competitor
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    add(1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    for (int k = 0; k < 9; k++) add(1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 1, 0);
    add(1, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 1, 0);
    add(1, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 1, 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n   = tbl[i].rstn;
      req     = tbl[i].req;
      in_data = tbl[i].din;
      sb.push_back({tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].valid, tbl[i].data});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt, sel, busy, out_valid, out_data} !== e) begin
        errors++;
        $display("FAIL vec%0d: got gnt=%b sel=%0d busy=%b valid=%b data=%b expected gnt=%b sel=%0d busy=%b valid=%b data=%b",
                 i, gnt, sel, busy, out_valid, out_data, e[8:5], e[4:3], e[2], e[1], e[0]);
      end
    end
    chk("ptr_after_preempt", {30'd0, dut.ptr_q}, 32'd0);

    // Asynchronous reset in the middle of a burst
    @(posedge clk); #1;
    rst_n = 1'b0; req = 4'b0000; in_data = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1; req = 4'b0100;
    @(negedge clk);
    chk("mid_idle_gnt", {28'd0, gnt}, 32'h0);
    @(negedge clk);
    chk("mid_gnt", {28'd0, gnt}, 32'h4);
    @(negedge clk);
    chk("mid_hold2_gnt", {28'd0, gnt}, 32'h4);
    chk("mid_hold2_cnt", {28'd0, dut.hold_q}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req = 4'b1111;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", {28'd0, gnt}, 32'h1);
    chk("post_rst_sel", {30'd0, sel}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one 4x1 bit multiplexer among four requesters.
- Each requester raises a request. The block grants exactly one, drives the mux select, and forwards that requester's data bit with a valid qualifier.
- Burst length per grant is bounded by a programmable hold limit so that no requester can starve the others.
- Sits in front of the 4x1 mux datapath and replaces hand-driven select stimulus with arbitrated control.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..15.
- HOLD_W, 4, width of the internal hold counter. Must hold MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i; level-sensitive.
- in_data  input  4  data bit per requester; bit i feeds mux input i.
- gnt  output  4  registered one-hot grant, or all-zero when idle.
- sel  output  2  registered mux select; equals the index of the set gnt bit.
- out_valid  output  1  high when the granted requester's req is still high.
- out_data  output  1  in_data[sel] when out_valid, else 0 (combinational from sel).
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state=IDLE, gnt=0000, sel=00, ptr=00, hold_cnt=0.
  - Outputs out_valid=0, out_data=0, busy=0.
  - Reset mid-burst drops the grant immediately; nothing is retained.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE:
  - If req != 0, on the next edge pick the first set bit in search order.
  - Set gnt/sel to it, hold_cnt=1, go to GRANT.
  - Grant latency is 1 cycle from req sampled high.
- GRANT, evaluated each edge with g = sel:
  - Release: req[g]==0. Set ptr=g+1 and re-arbitrate in the same edge over the remaining requests, starting at g+1.
    - Winner found: grant it, hold_cnt=1, stay in GRANT. There is no idle bubble.
    - No winner: gnt=0000 and go to IDLE.
  - Preempt: req[g]==1, hold_cnt==MAX_HOLD, and some other req bit is set. Set ptr=g+1, grant the first other requester from g+1, hold_cnt=1.
  - Saturate: req[g]==1, hold_cnt==MAX_HOLD, no other request. Keep the grant and hold hold_cnt at MAX_HOLD. Any later competing request preempts on its first sampled edge.
  - Continue: req[g]==1 and hold_cnt<MAX_HOLD. Keep the grant and increment hold_cnt.
- The current holder never wins a re-arbitration on the same edge it is released or preempted.
- Outputs:
  - out_valid = busy & req[sel].
  - out_data = out_valid & in_data[sel].
  - If a holder drops req, out_valid falls in that same cycle, before the release edge.
- Requests asserting and deasserting on the same edge are sampled as-is. No request is latched; a pulse shorter than one cycle between edges is never granted.
- Invariants:
  - gnt is one-hot or zero.
  - sel is constant while gnt is stable.
  - sel == index of the set gnt bit whenever gnt != 0. sel holds its last value when idle.
- MAX_HOLD=1 gives strict per-cycle round-robin under full load.

Test Plan:
- Reset, then req=0010 held. Next edge: gnt=0010, sel=01, busy=1. With in_data=0010: out_valid=1, out_data=1.
- req=1111 continuously, MAX_HOLD=4, from reset. gnt=0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, 0001; no gap cycles.
- req=0101; requester 0 drops req after 2 granted cycles. Same cycle: out_valid=0. Next edge: gnt=0100, sel=10, hold restarts. req=0000 later: gnt=0000, busy=0.
- Only req[3] high for 10 cycles: gnt stays 1000 (saturate). Raise req[1] at cycle 10: next edge gnt=0010, ptr=00.
- Mid-burst (gnt=0100, hold_cnt=2): pulse rst_n low between edges. gnt=0000, out_valid=0 immediately. After release with req=1111: first grant is 0001.
- Data path: sel=10 granted, in_data=1001 -> out_data=0; in_data=0100 -> out_data=1. Bench checks the gnt one-hot/zero invariant every cycle.
